// File: rtl/phase_acc_ctrl_pkg.sv
// phase_acc_ctrl_pkg: register map, CTRL bit positions and FSM encoding for phase_acc_ctrl
package phase_acc_ctrl_pkg;
  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_PHLO  = 2'd1;
  localparam logic [1:0] A_PHHI  = 2'd2;
  localparam logic [1:0] A_COUNT = 2'd3;
  localparam int B_EN      = 0;
  localparam int B_ONESHOT = 1;
  localparam int B_IRQ_EN  = 2;
  localparam int B_RUN     = 8;
  localparam int B_PEND    = 9;
  localparam int B_IRQF    = 10;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;
endpackage

// File: rtl/phase_acc_ctrl_core.sv
// pacc_core: RES-bit phase accumulator with enable, synchronous clear and carry-out wrap flag
module pacc_core #(
  parameter int unsigned RES = 20
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           clr_i,
  input  logic [RES-1:0] phase_i,
  output logic           msb_o,
  output logic           wrap_o
);
  logic [RES-1:0] acc_q, acc_d;
  logic [RES:0]   sum;
  // Next accumulator value; the extra sum bit is the wrap carry
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, phase_i};
    acc_d = clr_i ? '0 : en_i ? sum[RES-1:0] : acc_q;
  end
  // Accumulator register
  always_ff @(posedge clk_i) acc_q <= rst_i ? '0 : acc_d;
  assign msb_o  = acc_q[RES-1];
  assign wrap_o = en_i & sum[RES];
endmodule

// File: rtl/phase_acc_ctrl.sv
// phase_acc_ctrl: Wishbone-programmed sequencer for a phase-accumulator clock; interrupt logic only when PACC_IRQ_EN is defined
module phase_acc_ctrl
  import phase_acc_ctrl_pkg::*;
#(
  parameter int unsigned RES       = 20,
  parameter int unsigned PHASE_RST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        clk_o,
  output logic        tick_o,
  output logic        irq_o
);
  state_t           state_q, state_d;
  logic             en_q, en_d, os_q, os_d, pend_q, pend_d, ack_q, ack_d, tick_q, tick_d;
  logic [RES-1:0]   phase_shd_q, phase_shd_d, phase_act_q, phase_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic             wr, wr_c0, wr_lo, wr_hi, wr_cnt, en_w, wrap, clr, dec, done, apply, start_ok;
  logic [15:0]      ctrl_rd, phhi_rd, cnt_rd, rd;
`ifdef PACC_IRQ_EN
  logic             irq_en_q, irq_en_d, irqf_q, irqf_d, irq_q;
`endif

  pacc_core #(.RES(RES)) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q != S_IDLE),
    .clr_i  (clr),
    .phase_i(phase_act_q),
    .msb_o  (clk_o),
    .wrap_o (wrap)
  );

  // Register read view, presented only during the ack cycle
  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[B_EN]      = en_q;
    ctrl_rd[B_ONESHOT] = os_q;
    ctrl_rd[B_RUN]     = state_q != S_IDLE;
    ctrl_rd[B_PEND]    = pend_q;
`ifdef PACC_IRQ_EN
    ctrl_rd[B_IRQ_EN]  = irq_en_q;
    ctrl_rd[B_IRQF]    = irqf_q;
`else
    ctrl_rd[B_IRQ_EN]  = 1'b0;
    ctrl_rd[B_IRQF]    = 1'b0;
`endif
    phhi_rd            = '0;
    phhi_rd[RES-17:0]  = phase_shd_q[RES-1:16];
    cnt_rd             = '0;
    cnt_rd[CNT_W-1:0]  = cnt_q;
    rd = wb_adr_i == A_CTRL ? ctrl_rd : wb_adr_i == A_PHLO ? phase_shd_q[15:0] : wb_adr_i == A_PHHI ? phhi_rd : cnt_rd;
  end
  assign wb_dat_o = ack_q ? rd : '0;
  assign wb_ack_o = ack_q;
  assign tick_o   = tick_q;

  // Bus decode, shadow/pending commit, one-shot counter and run/stop sequencing
  always_comb begin
    ack_d  = wb_stb_i & wb_cyc_i & ~ack_q;
    wr     = ack_q & wb_stb_i & wb_cyc_i & wb_we_i;
    wr_c0  = wr & (wb_adr_i == A_CTRL) & wb_sel_i[0];
    wr_lo  = wr & (wb_adr_i == A_PHLO);
    wr_hi  = wr & (wb_adr_i == A_PHHI);
    wr_cnt = wr & (wb_adr_i == A_COUNT);
    en_w   = wr_c0 ? wb_dat_i[B_EN] : en_q;
    os_d   = wr_c0 ? wb_dat_i[B_ONESHOT] : os_q;
    phase_shd_d = phase_shd_q;
    for (int i = 0; i < RES; i++)
      if ((i < 16 ? wr_lo : wr_hi) && wb_sel_i[i[3]]) phase_shd_d[i] = wb_dat_i[i[3:0]];
    cnt_n = cnt_q;
    for (int i = 0; i < CNT_W; i++)
      if (wr_cnt && wb_sel_i[i[3]]) cnt_n[i] = wb_dat_i[i[3:0]];
    apply       = pend_q & ((state_q == S_IDLE) | wrap);
    phase_act_d = apply ? phase_shd_q : phase_act_q;
    pend_d      = wr_hi | (pend_q & ~apply);
    dec         = wrap & os_q & (cnt_q != '0) & ~wr_cnt;
    done        = dec & (cnt_q == CNT_W'(1));
    cnt_d       = wr_cnt ? cnt_n : dec ? cnt_q - CNT_W'(1) : cnt_q;
    clr         = done | (wrap & ~en_w);
    start_ok    = ~(os_q & (cnt_q == '0));
    state_d     = state_q == S_IDLE ? ((en_q & start_ok) ? S_RUN : S_IDLE) : clr ? S_IDLE : en_w ? S_RUN : S_STOP;
    en_d        = (done | ((state_q == S_IDLE) & en_q & ~start_ok)) ? 1'b0 : en_w;
    tick_d      = wrap;
`ifdef PACC_IRQ_EN
    irq_en_d    = wr_c0 ? wb_dat_i[B_IRQ_EN] : irq_en_q;
    irqf_d      = done | (irqf_q & ~(wr & (wb_adr_i == A_CTRL) & wb_sel_i[1] & wb_dat_i[B_IRQF]));
`endif
  end

  // State registers
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      os_q        <= 1'b0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      phase_shd_q <= RES'(PHASE_RST);
      phase_act_q <= RES'(PHASE_RST);
`ifdef PACC_IRQ_EN
      irq_en_q    <= 1'b0;
      irqf_q      <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      os_q        <= os_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      tick_q      <= tick_d;
      cnt_q       <= cnt_d;
      phase_shd_q <= phase_shd_d;
      phase_act_q <= phase_act_d;
`ifdef PACC_IRQ_EN
      irq_en_q    <= irq_en_d;
      irqf_q      <= irqf_d;
      irq_q       <= irqf_q & irq_en_q;
`endif
    end

`ifdef PACC_IRQ_EN
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif
endmodule
